// File: rtl/axis_eth_fcs_strip_64.sv
// Strips the trailing 4-byte FCS from 64-bit AXI4-Stream Ethernet frames.
// Holds one beat so the tail can be trimmed; registered output with a skid stage.
module axis_eth_fcs_strip_64 #(
  parameter int RUNT_DROP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        error_runt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TAIL = 2'd2
  } state_t;

  function automatic logic [7:0] lowMask(input logic [3:0] bytes);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < int'(bytes));
    end
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [63:0] holdData_q, holdData_d;
  logic [63:0] tailData_q, tailData_d;
  logic [7:0]  tailKeep_q, tailKeep_d;
  logic        tailUser_q, tailUser_d;

  logic        sReady_q;
  logic        readyInt_q;
  logic        readyIntEarly;
  logic        busy_q;
  logic        errorRunt_q;
  logic        runtPulse;

  logic        sAccept;
  logic [3:0]  lastBytes;

  logic        intValid;
  logic [63:0] intData;
  logic [7:0]  intKeep;
  logic        intLast;
  logic        intUser;

  logic        outValid_q, outValid_d;
  logic [63:0] outData_q;
  logic [7:0]  outKeep_q;
  logic        outLast_q;
  logic        outUser_q;

  logic        skidValid_q, skidValid_d;
  logic [63:0] skidData_q;
  logic [7:0]  skidKeep_q;
  logic        skidLast_q;
  logic        skidUser_q;

  logic        loadOut;
  logic        loadSkid;
  logic        skidToOut;

  assign sAccept   = s_axis_tvalid && sReady_q;
  assign lastBytes = 4'($countones(s_axis_tkeep));

  // Framing FSM: decides what (if anything) each accepted beat releases.
  always_comb begin
    state_d    = state_q;
    holdData_d = holdData_q;
    tailData_d = tailData_q;
    tailKeep_d = tailKeep_q;
    tailUser_d = tailUser_q;
    runtPulse  = 1'b0;
    intValid   = 1'b0;
    intData    = '0;
    intKeep    = '0;
    intLast    = 1'b0;
    intUser    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sAccept) begin
          if (!s_axis_tlast) begin
            holdData_d = s_axis_tdata;
            state_d    = HOLD;
          end else if (lastBytes > 4'd4) begin
            intValid = 1'b1;
            intData  = s_axis_tdata;
            intKeep  = lowMask(4'(lastBytes - 4'd4));
            intLast  = 1'b1;
            intUser  = s_axis_tuser;
          end else begin
            runtPulse = 1'b1;
            if (RUNT_DROP == 0) begin
              intValid = 1'b1;
              intKeep  = 8'h01;
              intLast  = 1'b1;
              intUser  = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (sAccept) begin
          intValid = 1'b1;
          intData  = holdData_q;
          if (!s_axis_tlast) begin
            intKeep    = 8'hFF;
            holdData_d = s_axis_tdata;
          end else if (lastBytes <= 4'd4) begin
            // Part (or all) of the FCS lives in the held beat; trim it there.
            intKeep = lowMask(4'(lastBytes + 4'd4));
            intLast = 1'b1;
            intUser = s_axis_tuser;
            state_d = IDLE;
          end else begin
            intKeep    = 8'hFF;
            tailData_d = s_axis_tdata;
            tailKeep_d = lowMask(4'(lastBytes - 4'd4));
            tailUser_d = s_axis_tuser;
            state_d    = TAIL;
          end
        end
      end

      TAIL: begin
        if (readyInt_q) begin
          intValid = 1'b1;
          intData  = tailData_q;
          intKeep  = tailKeep_q;
          intLast  = 1'b1;
          intUser  = tailUser_q;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output/skid steering; readyIntEarly predicts room for one more beat next cycle.
  always_comb begin
    readyIntEarly = m_axis_tready || (!skidValid_q && (!outValid_q || !intValid));
    outValid_d    = outValid_q;
    skidValid_d   = skidValid_q;
    loadOut       = 1'b0;
    loadSkid      = 1'b0;
    skidToOut     = 1'b0;
    if (readyInt_q) begin
      if (m_axis_tready || !outValid_q) begin
        outValid_d = intValid;
        loadOut    = 1'b1;
      end else begin
        skidValid_d = intValid;
        loadSkid    = 1'b1;
      end
    end else if (m_axis_tready) begin
      outValid_d  = skidValid_q;
      skidValid_d = 1'b0;
      skidToOut   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      holdData_q  <= '0;
      tailData_q  <= '0;
      tailKeep_q  <= '0;
      tailUser_q  <= 1'b0;
      sReady_q    <= 1'b0;
      readyInt_q  <= 1'b0;
      busy_q      <= 1'b0;
      errorRunt_q <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outKeep_q   <= '0;
      outLast_q   <= 1'b0;
      outUser_q   <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidKeep_q  <= '0;
      skidLast_q  <= 1'b0;
      skidUser_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdData_q  <= holdData_d;
      tailData_q  <= tailData_d;
      tailKeep_q  <= tailKeep_d;
      tailUser_q  <= tailUser_d;
      sReady_q    <= readyIntEarly && (state_d != TAIL);
      readyInt_q  <= readyIntEarly;
      busy_q      <= (state_d != IDLE);
      errorRunt_q <= runtPulse;
      outValid_q  <= outValid_d;
      skidValid_q <= skidValid_d;
      if (loadOut) begin
        outData_q <= intData;
        outKeep_q <= intKeep;
        outLast_q <= intLast;
        outUser_q <= intUser;
      end else if (skidToOut) begin
        outData_q <= skidData_q;
        outKeep_q <= skidKeep_q;
        outLast_q <= skidLast_q;
        outUser_q <= skidUser_q;
      end
      if (loadSkid) begin
        skidData_q <= intData;
        skidKeep_q <= intKeep;
        skidLast_q <= intLast;
        skidUser_q <= intUser;
      end
    end
  end

  assign s_axis_tready = sReady_q;
  assign m_axis_tvalid = outValid_q;
  assign m_axis_tdata  = outData_q;
  assign m_axis_tkeep  = outKeep_q;
  assign m_axis_tlast  = outLast_q;
  assign m_axis_tuser  = outUser_q;
  assign busy          = busy_q;
  assign error_runt    = errorRunt_q;

endmodule

// File: tb/tb_axis_eth_fcs_strip_64.sv
// Randomized self-checking bench for axis_eth_fcs_strip_64 with a frame-level reference model.
// A second instance (RUNT_DROP=1) is only fed during the runt scenario.
module tb_axis_eth_fcs_strip_64;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        fullCmp;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [63:0] sData;
  logic [7:0]  sKeep;
  logic        sValid;
  logic        sLast;
  logic        sUser;
  logic        sReady;
  logic [63:0] mData;
  logic [7:0]  mKeep;
  logic        mValid;
  logic        mReady;
  logic        mLast;
  logic        mUser;
  logic        busy0;
  logic        errRunt0;

  logic        drive1;
  logic        sValid1;
  logic        sReady1;
  logic [63:0] m1Data;
  logic [7:0]  m1Keep;
  logic        mValid1;
  logic        m1Last;
  logic        m1User;
  logic        busy1;
  logic        errRunt1;

  logic        randReady;
  logic        mReadyFixed;

  int cmpCount;
  int errCount;
  int gotBeats;
  int runtPulses0;
  int runtPulses1;
  int dropBeats;
  logic [73:0] lastDut1Beat;

  beat_t expQ[$];
  logic [7:0] frameBytes [0:255];

  assign sValid1 = sValid & drive1;

  axis_eth_fcs_strip_64 #(.RUNT_DROP(0)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tvalid(sValid),
    .s_axis_tready(sReady), .s_axis_tlast(sLast), .s_axis_tuser(sUser),
    .m_axis_tdata(mData), .m_axis_tkeep(mKeep), .m_axis_tvalid(mValid),
    .m_axis_tready(mReady), .m_axis_tlast(mLast), .m_axis_tuser(mUser),
    .busy(busy0), .error_runt(errRunt0)
  );

  axis_eth_fcs_strip_64 #(.RUNT_DROP(1)) dutDrop (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tvalid(sValid1),
    .s_axis_tready(sReady1), .s_axis_tlast(sLast), .s_axis_tuser(sUser),
    .m_axis_tdata(m1Data), .m_axis_tkeep(m1Keep), .m_axis_tvalid(mValid1),
    .m_axis_tready(1'b1), .m_axis_tlast(m1Last), .m_axis_tuser(m1User),
    .busy(busy1), .error_runt(errRunt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: fixed or 50% random, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mReady = randReady ? 1'($urandom_range(0, 1)) : mReadyFixed;
    end
  end

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  initial begin
    logic [74:0] prevBeat;
    logic        prevStall;
    beat_t       e;
    logic [63:0] mask;
    prevStall = 1'b0;
    prevBeat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          cmpCount++;
          if ({mValid, mData, mKeep, mLast, mUser} !== prevBeat) begin
            errCount++;
            $display("[TB] FAIL stall_stable: got %h required %h", {mValid, mData, mKeep, mLast, mUser}, prevBeat);
          end
        end
        if (mValid && mReady) begin
          gotBeats++;
          cmpCount++;
          if (expQ.size() == 0) begin
            errCount++;
            $display("[TB] FAIL extra_beat: got data=%h keep=%h last=%b user=%b required no beat", mData, mKeep, mLast, mUser);
          end else begin
            e = expQ.pop_front();
            mask = '1;
            if (!e.fullCmp) begin
              for (int i = 0; i < 8; i++) mask[i*8 +: 8] = e.keep[i] ? 8'hFF : 8'h00;
            end
            if (((mData & mask) !== (e.data & mask)) || (mKeep !== e.keep) ||
                (mLast !== e.last) || (mUser !== e.user)) begin
              errCount++;
              $display("[TB] FAIL out_beat: got data=%h keep=%h last=%b user=%b required data=%h keep=%h last=%b user=%b",
                       mData & mask, mKeep, mLast, mUser, e.data & mask, e.keep, e.last, e.user);
            end
          end
        end
        prevStall = mValid && !mReady;
        prevBeat  = {mValid, mData, mKeep, mLast, mUser};
        if (errRunt0) runtPulses0++;
        if (errRunt1) runtPulses1++;
        if (mValid1) begin
          dropBeats++;
          lastDut1Beat = {m1Data, m1Keep, m1Last, m1User};
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fillBytes(input int len);
    for (int i = 0; i < len; i++) frameBytes[i] = 8'($urandom);
  endtask

  // Reference model: a frame of len bytes becomes its first len-4 bytes packed 8 per beat.
  task automatic pushExpected(input int len, input logic user);
    beat_t b;
    int    p;
    if (len <= 4) begin
      b = '{data: 64'h0, keep: 8'h01, last: 1'b1, user: 1'b1, fullCmp: 1'b1};
      expQ.push_back(b);
    end else begin
      p = len - 4;
      for (int base = 0; base < p; base += 8) begin
        b = '0;
        for (int i = 0; i < 8; i++) begin
          if (base + i < p) begin
            b.data[i*8 +: 8] = frameBytes[base + i];
            b.keep[i] = 1'b1;
          end
        end
        b.last = (base + 8 >= p);
        b.user = b.last ? user : 1'b0;
        expQ.push_back(b);
      end
    end
  endtask

  task automatic drainOutput();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    waitCycles(6);
  endtask

  task automatic sendFrame(input int len, input logic user, input int maxBeats, output int waits);
    int beats;
    int w;
    logic [63:0] d;
    logic [7:0]  k;
    waits = 0;
    beats = (len + 7) / 8;
    for (int b = 0; b < beats && b < maxBeats; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < len) begin
          d[i*8 +: 8] = frameBytes[b * 8 + i];
          k[i] = 1'b1;
        end else begin
          d[i*8 +: 8] = 8'($urandom);
          k[i] = 1'b0;
        end
      end
      sData  = d;
      sKeep  = k;
      sLast  = (b == beats - 1);
      sUser  = (b == beats - 1) ? user : 1'($urandom_range(0, 1));
      sValid = 1'b1;
      w = 0;
      forever begin
        @(negedge clk);
        if (sReady) break;
        w++;
        if (w > 2000) begin
          errCount++;
          $display("[TB] FAIL accept_timeout: got s_axis_tready=0 for %0d cycles required 1", w);
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
          $fatal(1, "[TB] input handshake timed out");
        end
      end
      waits += w;
      @(posedge clk);
      #1;
    end
    sValid = 1'b0;
    sLast  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    cmpCount++;
    if ({sReady, mValid, mLast, mUser, busy0, errRunt0} !== 6'b0) begin
      errCount++;
      $display("[TB] FAIL reset_outputs: got %b required 000000", {sReady, mValid, mLast, mUser, busy0, errRunt0});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmpCount++;
    if (sReady !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL ready_after_reset: got %b required 1", sReady);
    end
  endtask

  task automatic test_full_frame();
    int waits;
    gotBeats = 0;
    fillBytes(64);
    pushExpected(64, 1'b0);
    sendFrame(64, 1'b0, 1000, waits);
    cmpCount++;
    if (waits !== 0) begin
      errCount++;
      $display("[TB] FAIL f64_no_stall: got %0d wait cycles required 0", waits);
    end
    drainOutput();
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != 8) begin
      errCount++;
      $display("[TB] FAIL f64_beats: got %0d beats (%0d pending) required 8", gotBeats, expQ.size());
    end
  endtask

  task automatic test_tail_beat();
    int waits;
    gotBeats = 0;
    fillBytes(70);
    pushExpected(70, 1'b1);
    sendFrame(70, 1'b1, 1000, waits);
    cmpCount++;
    if (sReady !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL f70_stall: got s_axis_tready=%b required 0", sReady);
    end
    @(posedge clk);
    #1;
    cmpCount++;
    if (sReady !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL f70_resume: got s_axis_tready=%b required 1", sReady);
    end
    drainOutput();
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != 9 || waits != 0) begin
      errCount++;
      $display("[TB] FAIL f70_beats: got %0d beats, %0d waits required 9 beats, 0 waits", gotBeats, waits);
    end
  endtask

  task automatic test_fcs_in_last();
    int waits;
    gotBeats = 0;
    fillBytes(68);
    pushExpected(68, 1'b0);
    sendFrame(68, 1'b0, 1000, waits);
    cmpCount++;
    if (sReady !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL f68_no_stall: got s_axis_tready=%b required 1", sReady);
    end
    drainOutput();
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != 8) begin
      errCount++;
      $display("[TB] FAIL f68_beats: got %0d beats required 8", gotBeats);
    end
  endtask

  task automatic test_runt();
    int waits;
    gotBeats    = 0;
    runtPulses0 = 0;
    runtPulses1 = 0;
    dropBeats   = 0;
    drive1      = 1'b1;
    fillBytes(3);
    pushExpected(3, 1'b0);
    sendFrame(3, 1'b0, 1000, waits);
    drive1 = 1'b0;
    drainOutput();
    cmpCount++;
    if (gotBeats != 1 || expQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL runt_emit: got %0d beats required 1", gotBeats);
    end
    cmpCount++;
    if (runtPulses0 != 1 || runtPulses1 != 1) begin
      errCount++;
      $display("[TB] FAIL runt_pulse: got %0d/%0d pulses required 1/1", runtPulses0, runtPulses1);
    end
    cmpCount++;
    if (dropBeats != 0) begin
      errCount++;
      $display("[TB] FAIL runt_drop: got %0d beats (last %h) required 0", dropBeats, lastDut1Beat);
    end
    cmpCount++;
    if (busy1 !== 1'b0 || sReady1 !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL runt_drop_idle: got busy=%b ready=%b required busy=0 ready=1", busy1, sReady1);
    end
  endtask

  task automatic test_back_to_back();
    int waits;
    gotBeats  = 0;
    randReady = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fillBytes(66);
      pushExpected(66, 1'($urandom_range(0, 1)));
      sendFrame(66, expQ[expQ.size() - 1].user, 1000, waits);
    end
    drainOutput();
    randReady = 1'b0;
    waitCycles(2);
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != 48) begin
      errCount++;
      $display("[TB] FAIL b2b_beats: got %0d beats (%0d pending) required 48", gotBeats, expQ.size());
    end
  endtask

  task automatic test_random_lengths();
    int waits;
    int len;
    int expBeats;
    int expRunts;
    logic user;
    gotBeats    = 0;
    runtPulses0 = 0;
    expBeats    = 0;
    expRunts    = 0;
    randReady   = 1'b1;
    for (int f = 0; f < 14; f++) begin
      len  = (f < 2) ? 4 + f * 9 : $urandom_range(1, 90);
      user = 1'($urandom_range(0, 1));
      if (len <= 4) begin
        expRunts++;
        expBeats++;
      end else begin
        expBeats += (len - 4 + 7) / 8;
      end
      fillBytes(len);
      pushExpected(len, user);
      sendFrame(len, user, 1000, waits);
    end
    drainOutput();
    randReady = 1'b0;
    waitCycles(2);
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != expBeats || runtPulses0 != expRunts) begin
      errCount++;
      $display("[TB] FAIL rand_len: got %0d beats, %0d runts required %0d beats, %0d runts",
               gotBeats, runtPulses0, expBeats, expRunts);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waits;
    mReadyFixed = 1'b0;
    mReady      = 1'b0;
    fillBytes(60);
    sendFrame(60, 1'b0, 2, waits);
    cmpCount++;
    if (busy0 !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL mid_busy: got %b required 1", busy0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmpCount++;
    if ({mValid, busy0, sReady} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL mid_reset_async: got valid/busy/ready=%b required 000", {mValid, busy0, sReady});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    mReadyFixed = 1'b1;
    mReady      = 1'b1;
    waitCycles(1);
    gotBeats = 0;
    fillBytes(60);
    pushExpected(60, 1'b0);
    sendFrame(60, 1'b0, 1000, waits);
    drainOutput();
    cmpCount++;
    if (expQ.size() != 0 || gotBeats != 7) begin
      errCount++;
      $display("[TB] FAIL mid_next_frame: got %0d beats required 7", gotBeats);
    end
  endtask

  initial begin
    rst         = 1'b1;
    sData       = '0;
    sKeep       = '0;
    sValid      = 1'b0;
    sLast       = 1'b0;
    sUser       = 1'b0;
    drive1      = 1'b0;
    randReady   = 1'b0;
    mReadyFixed = 1'b1;
    mReady      = 1'b1;
    cmpCount    = 0;
    errCount    = 0;
    gotBeats    = 0;
    runtPulses0 = 0;
    runtPulses1 = 0;
    dropBeats   = 0;
    lastDut1Beat = '0;

    test_reset();
    test_full_frame();
    test_tail_beat();
    test_fcs_in_last();
    test_runt();
    test_back_to_back();
    test_random_lengths();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/axis_eth_fcs_strip_64.md
Name: axis_eth_fcs_strip_64

Overview:
Removes the trailing 4-byte FCS from 64-bit AXI4-Stream Ethernet frames. It sits directly downstream of the 64-bit FCS checker, which passes the FCS bytes through and flags bad frames in tuser on the last beat. It holds one beat so the tail can be trimmed once the last beat is seen. The error flag is carried through to the trimmed last beat. Full throughput, except one stall cycle per frame whose last input beat carries more than 4 bytes.

Parameters:
RUNT_DROP, 0, 1 = discard a frame of 4 bytes or fewer; 0 = emit it as a 1-byte beat with tuser=1

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset; asynchronous, active-high
s_axis_tdata  in  64  input data, byte 0 in [7:0]
s_axis_tkeep  in  8  input byte enables, contiguous from bit 0
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready (registered)
s_axis_tlast  in  1  end of frame
s_axis_tuser  in  1  frame error, sampled on last beat only
m_axis_tdata  out  64  output data
m_axis_tkeep  out  8  output byte enables, never 0 when valid
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  end of frame
m_axis_tuser  out  1  frame error, meaningful on last beat
busy  out  1  high while a held beat or pending tail beat exists
error_runt  out  1  1-cycle pulse when a frame of 4 bytes or fewer is received

Behaviour:
- Reset (async assert, sync release): all valid flags cleared, held beat discarded, state IDLE.
- During reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, error_runt=0.
- s_axis_tready rises the first cycle after reset release when downstream has space.
- Output stage: registered output plus one temp (skid) register.
  - Ready is generated early, so back-to-back transfers sustain 1 beat/clk.
  - No beat is lost or duplicated under any m_axis_tready pattern.
  - m_axis_* is stable while m_axis_tvalid && !m_axis_tready.
- Let n = popcount(tkeep) of the last input beat L, and H = the held previous beat of the same frame (always 8 bytes).
- States:
  - IDLE: no held beat.
    - Non-last beat accepted -> store in H, go to HOLD.
    - Last beat with n>4 -> emit L with keep = (1<<(n-4))-1, tlast=1, tuser=L.tuser; stay IDLE.
    - Last beat with n<=4 (runt) -> pulse error_runt. If RUNT_DROP=0, emit a beat with tdata=0, tkeep=8'h01, tlast=1, tuser=1. If RUNT_DROP=1, emit nothing.
  - HOLD: H valid.
    - Non-last beat accepted -> emit H (tlast=0), replace H with the new beat.
    - Last beat with n<4 -> emit H with keep = (1<<(4+n))-1, tlast=1, tuser=L.tuser; go to IDLE.
    - Last beat with n=4 -> emit H with keep=8'hFF, tlast=1, tuser=L.tuser; go to IDLE.
    - Last beat with n>4 -> emit H (tlast=0), save L's data, trimmed keep and tuser, drop s_axis_tready for 1 cycle; go to TAIL.
  - TAIL: emit the saved beat (keep = n-4 bytes, tlast=1). When the output stage accepts it, go to IDLE and re-enable s_axis_tready.
- Latency: an emitted beat appears on m_axis the cycle after the input beat that released it is accepted.
- tuser on non-last input beats is ignored; tuser on output non-last beats is 0.
- busy = (state != IDLE), registered.
- Non-contiguous tkeep on input: undefined, not checked.
- Reset mid-frame: the partial frame is discarded and the next beat after release starts a new frame.

Test Plan:
1. 64-byte frame (8 full beats, FCS in bytes 60-63), m_axis_tready=1 -> 8 output beats; last has tkeep=8'h0F, tlast=1, tuser=0. Data matches input bytes 0-59, no stall cycles.
2. 70-byte frame (last input tkeep=8'h3F) with tuser=1 on last -> output beats 1-8 full; beat 9 tkeep=8'h03, tlast=1, tuser=1. s_axis_tready low for exactly 1 cycle after the last input beat.
3. 68-byte frame (last input tkeep=8'h0F) -> 8 output beats; last has tkeep=8'hFF, tlast=1. The last input beat produces no output beat.
4. 3-byte frame (tkeep=8'h07, tlast=1): RUNT_DROP=0 -> one beat tkeep=8'h01, tdata=0, tuser=1, error_runt pulses once. RUNT_DROP=1 -> no output, error_runt pulses once.
5. Back-to-back 66-byte frames with random m_axis_tready (50%) -> byte-exact match against the scoreboard model (each frame = input minus last 4 bytes). No overflow, tvalid/tdata stable while stalled.
6. Assert rst asynchronously mid-frame (between clock edges, HOLD state) -> m_axis_tvalid=0 and busy=0 immediately. After release, a following 60-byte frame outputs 56 bytes correctly, with no leftover beats.
